// File: rtl/alarm_pkg.sv
// Shared constants, state encodings and BCD helpers for the alarm bank.
package alarm_pkg;

    localparam logic [3:0] DIG_SEP   = 4'd10;
    localparam logic [3:0] DIG_BLANK = 4'd11;
    localparam logic [3:0] DIG_A     = 4'd12;
    localparam logic [3:0] DIG_P     = 4'd13;

    localparam logic [4:0] DISABLED_HOUR = 5'd24;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SET_HOUR = 2'd1,
        ST_SET_MIN  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        BLINK_NONE = 2'd0,
        BLINK_HOUR = 2'd1,
        BLINK_MIN  = 2'd2
    } blink_t;

    function automatic logic [3:0] tens(input logic [5:0] v);
        return 4'(v / 6'd10);
    endfunction

    function automatic logic [3:0] ones(input logic [5:0] v);
        return 4'(v % 6'd10);
    endfunction

endpackage

// File: rtl/alarm_digit_fmt.sv
// Turns an hours/minutes pair into six display digit codes (24h or 12h),
// blanking the field under edit during the blink phase.
module alarm_digit_fmt
    import alarm_pkg::*;
(
    input  logic [4:0] hours,
    input  logic [5:0] minutes,
    input  logic       mode_12h,
    input  blink_t     blink_field,
    input  logic       blink_phase,
    input  logic       disabled,
    output logic [3:0] dig0,
    output logic [3:0] dig1,
    output logic [3:0] dig2,
    output logic [3:0] dig3,
    output logic [3:0] dig4,
    output logic [3:0] dig5
);

    logic [4:0] hour12;
    logic       hide_h;
    logic       hide_m;

    always_comb begin
        hour12 = hours;
        if (hours == 5'd0)
            hour12 = 5'd12;
        else if (hours > 5'd12)
            hour12 = hours - 5'd12;

        hide_h = blink_phase && (blink_field == BLINK_HOUR);
        hide_m = blink_phase && (blink_field == BLINK_MIN);

        dig0 = DIG_BLANK;
        dig1 = DIG_BLANK;
        dig2 = DIG_BLANK;
        dig3 = DIG_BLANK;
        dig4 = DIG_BLANK;
        dig5 = DIG_BLANK;

        if (!disabled) begin
            if (!mode_12h) begin
                dig0 = hide_h ? DIG_BLANK : tens({1'b0, hours});
                dig1 = hide_h ? DIG_BLANK : ones({1'b0, hours});
                dig2 = hide_m ? DIG_BLANK : tens(minutes);
                dig3 = hide_m ? DIG_BLANK : ones(minutes);
                dig4 = 4'd0;
                dig5 = 4'd0;
            end else begin
                // AM/PM marker and separator stay lit while the fields blink
                dig0 = (hours < 5'd12) ? DIG_A : DIG_P;
                dig1 = DIG_SEP;
                dig2 = hide_h ? DIG_BLANK : tens({1'b0, hour12});
                dig3 = hide_h ? DIG_BLANK : ones({1'b0, hour12});
                dig4 = hide_m ? DIG_BLANK : tens(minutes);
                dig5 = hide_m ? DIG_BLANK : ones(minutes);
            end
        end
    end

endmodule

// File: rtl/alarm_bank.sv
// Multi-slot alarm: slot storage, edit FSM, minute matcher, ring/snooze timers.
// state       | meaning
// ST_IDLE     | browsing slots; set starts an edit, clear disables the slot
// ST_SET_HOUR | editing hour of the selected slot
// ST_SET_MIN  | editing minute; set commits the edit
module alarm_bank
    import alarm_pkg::*;
#(
    parameter int NUM_ALARMS = 4,
    parameter int SLOT_W     = 2,
    parameter int SNOOZE_MIN = 5,
    parameter int RING_MIN   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        currentMode,
    input  logic              real_quarter,
    input  logic              set,
    input  logic              display,
    input  logic              clear,
    input  logic              next,
    input  logic              snooze,
    input  logic [4:0]        cur_hours,
    input  logic [5:0]        cur_minutes,
    input  logic              minute_tick,
    output logic [SLOT_W-1:0] sel_slot,
    output logic [4:0]        alarm_hours,
    output logic [5:0]        alarm_minutes,
    output logic              ring,
    output logic [SLOT_W-1:0] ring_slot,
    output logic              snoozing,
    output logic [3:0]        dig0,
    output logic [3:0]        dig1,
    output logic [3:0]        dig2,
    output logic [3:0]        dig3,
    output logic [3:0]        dig4,
    output logic [3:0]        dig5
);

    state_t            state, state_nxt;
    logic [4:0]        slot_hours   [NUM_ALARMS];
    logic [5:0]        slot_minutes [NUM_ALARMS];
    logic [4:0]        edit_hours;
    logic [5:0]        edit_minutes;
    logic              mode_12h;
    logic [5:0]        ring_timer;
    logic [5:0]        snooze_timer;
    logic              hit;
    logic [SLOT_W-1:0] hit_idx;
    logic              alarm_active, edit_en, ring_clear, ring_snooze;
    logic              b_clear, b_set, b_disp, b_next;
    logic              load_edit, inc_hour, inc_min, commit, clear_slot, toggle_mode, step_slot;
    logic              sel_disabled;
    blink_t            blink_field;

    assign alarm_hours   = slot_hours[sel_slot];
    assign alarm_minutes = slot_minutes[sel_slot];
    assign sel_disabled  = (alarm_hours == DISABLED_HOUR);

    // A clear aimed at a sounding alarm is swallowed by the ring logic, so
    // the edit FSM sees no button at all in that cycle.
    assign alarm_active = ring | snoozing;
    assign edit_en      = (currentMode == 2'd1);
    assign ring_clear   = clear & alarm_active;
    assign ring_snooze  = snooze & ring & ~clear;
    assign b_clear      = edit_en & clear & ~alarm_active;
    assign b_set        = edit_en & ~clear & set;
    assign b_disp       = edit_en & ~clear & ~set & display;
    assign b_next       = edit_en & ~clear & ~set & ~display & next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        load_edit   = 1'b0;
        inc_hour    = 1'b0;
        inc_min     = 1'b0;
        commit      = 1'b0;
        clear_slot  = 1'b0;
        toggle_mode = 1'b0;
        step_slot   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (b_clear) begin
                    clear_slot = 1'b1;
                end else if (b_set) begin
                    load_edit = 1'b1;
                    state_nxt = ST_SET_HOUR;
                end else if (b_disp) begin
                    toggle_mode = 1'b1;
                end else if (b_next) begin
                    step_slot = 1'b1;
                end
            end
            ST_SET_HOUR: begin
                if (b_clear)     state_nxt = ST_IDLE;
                else if (b_set)  state_nxt = ST_SET_MIN;
                else if (b_disp) inc_hour  = 1'b1;
            end
            ST_SET_MIN: begin
                if (b_clear) begin
                    state_nxt = ST_IDLE;
                end else if (b_set) begin
                    commit    = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (b_disp) begin
                    inc_min = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_ALARMS; i++) begin
                slot_hours[i]   <= DISABLED_HOUR;
                slot_minutes[i] <= '0;
            end
            sel_slot     <= '0;
            mode_12h     <= 1'b0;
            edit_hours   <= '0;
            edit_minutes <= '0;
        end else begin
            if (clear_slot)
                slot_hours[sel_slot] <= DISABLED_HOUR;
            if (commit) begin
                slot_hours[sel_slot]   <= edit_hours;
                slot_minutes[sel_slot] <= edit_minutes;
            end
            if (toggle_mode)
                mode_12h <= ~mode_12h;
            if (step_slot)
                sel_slot <= (sel_slot == SLOT_W'(NUM_ALARMS - 1)) ? '0 : sel_slot + 1'b1;
            if (load_edit) begin
                edit_hours   <= sel_disabled ? 5'd0 : alarm_hours;
                edit_minutes <= sel_disabled ? 6'd0 : alarm_minutes;
            end
            if (inc_hour)
                edit_hours <= (edit_hours == 5'd23) ? 5'd0 : edit_hours + 5'd1;
            if (inc_min)
                edit_minutes <= (edit_minutes == 6'd59) ? 6'd0 : edit_minutes + 6'd1;
        end
    end

    // Lowest enabled matching slot wins; compares stored (pre-commit) values.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
            if (slot_hours[i] != DISABLED_HOUR && slot_hours[i] == cur_hours &&
                slot_minutes[i] == cur_minutes) begin
                hit     = 1'b1;
                hit_idx = SLOT_W'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ring         <= 1'b0;
            ring_slot    <= '0;
            snoozing     <= 1'b0;
            ring_timer   <= '0;
            snooze_timer <= '0;
        end else if (ring_clear) begin
            ring         <= 1'b0;
            snoozing     <= 1'b0;
            ring_timer   <= '0;
            snooze_timer <= '0;
        end else if (ring_snooze) begin
            ring         <= 1'b0;
            snoozing     <= 1'b1;
            ring_timer   <= '0;
            snooze_timer <= 6'(SNOOZE_MIN);
        end else if (snoozing && slot_hours[ring_slot] == DISABLED_HOUR) begin
            snoozing     <= 1'b0;
            snooze_timer <= '0;
        end else if (minute_tick) begin
            if (ring) begin
                if (ring_timer <= 6'd1) begin
                    ring       <= 1'b0;
                    ring_timer <= '0;
                end else begin
                    ring_timer <= ring_timer - 6'd1;
                end
            end else if (snoozing) begin
                if (snooze_timer <= 6'd1) begin
                    snoozing     <= 1'b0;
                    snooze_timer <= '0;
                    ring         <= 1'b1;
                    ring_timer   <= 6'(RING_MIN);
                end else begin
                    snooze_timer <= snooze_timer - 6'd1;
                end
            end else if (hit) begin
                ring       <= 1'b1;
                ring_slot  <= hit_idx;
                ring_timer <= 6'(RING_MIN);
            end
        end
    end

    always_comb begin
        unique case (state)
            ST_SET_HOUR: blink_field = BLINK_HOUR;
            ST_SET_MIN:  blink_field = BLINK_MIN;
            default:     blink_field = BLINK_NONE;
        endcase
    end

    alarm_digit_fmt u_fmt (
        .hours       ((state == ST_IDLE) ? alarm_hours : edit_hours),
        .minutes     ((state == ST_IDLE) ? alarm_minutes : edit_minutes),
        .mode_12h    (mode_12h),
        .blink_field (blink_field),
        .blink_phase (real_quarter),
        .disabled    ((state == ST_IDLE) && sel_disabled),
        .dig0        (dig0),
        .dig1        (dig1),
        .dig2        (dig2),
        .dig3        (dig3),
        .dig4        (dig4),
        .dig5        (dig5)
    );

endmodule

// File: tb/tb_alarm_bank.sv
// Self-checking bench for alarm_bank: directed scenarios plus random button
// traffic compared against a behavioural model of slots, editing and ringing.
module tb_alarm_bank;

    localparam int N   = 4;
    localparam int SW  = 2;
    localparam int SNZ = 5;
    localparam int RNG = 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [1:0]    currentMode = 2'd0;
    logic          real_quarter = 1'b0;
    logic          set = 1'b0, display = 1'b0, clear = 1'b0, next = 1'b0;
    logic          snooze = 1'b0, minute_tick = 1'b0;
    logic [4:0]    cur_hours = 5'd0;
    logic [5:0]    cur_minutes = 6'd0;
    logic [SW-1:0] sel_slot, ring_slot;
    logic [4:0]    alarm_hours;
    logic [5:0]    alarm_minutes;
    logic          ring, snoozing;
    logic [3:0]    dig0, dig1, dig2, dig3, dig4, dig5;
    logic [23:0]   dut_dig;
    logic [40:0]   dut_state;

    alarm_bank #(.NUM_ALARMS(N), .SLOT_W(SW), .SNOOZE_MIN(SNZ), .RING_MIN(RNG)) dut (
        .clk(clk), .reset(reset), .currentMode(currentMode), .real_quarter(real_quarter),
        .set(set), .display(display), .clear(clear), .next(next), .snooze(snooze),
        .cur_hours(cur_hours), .cur_minutes(cur_minutes), .minute_tick(minute_tick),
        .sel_slot(sel_slot), .alarm_hours(alarm_hours), .alarm_minutes(alarm_minutes),
        .ring(ring), .ring_slot(ring_slot), .snoozing(snoozing),
        .dig0(dig0), .dig1(dig1), .dig2(dig2), .dig3(dig3), .dig4(dig4), .dig5(dig5)
    );

    always #5 clk = ~clk;

    assign dut_dig   = {dig0, dig1, dig2, dig3, dig4, dig5};
    assign dut_state = {sel_slot, alarm_hours, alarm_minutes, ring, ring_slot, snoozing, dut_dig};

    int n_cmp = 0;
    int n_fail = 0;

    // Behavioural model: phase 0 = browsing, 1 = editing hour, 2 = editing minute.
    int   m_h[N];
    int   m_m[N];
    int   m_sel, m_phase, m_eh, m_em, m_rslot, m_left;
    logic m_12h, m_ring, m_snz;

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_h[i] = 24;
            m_m[i] = 0;
        end
        m_sel = 0; m_phase = 0; m_eh = 0; m_em = 0; m_rslot = 0; m_left = 0;
        m_12h = 1'b0; m_ring = 1'b0; m_snz = 1'b0;
    endtask

    function automatic logic [23:0] exp_dig();
        int h, m, h12;
        logic hb, mb;
        logic [3:0] d0, d1, d2, d3, d4, d5;
        if (m_phase == 0) begin
            h = m_h[m_sel];
            m = m_m[m_sel];
            if (h == 24) return 24'hBBBBBB;
        end else begin
            h = m_eh;
            m = m_em;
        end
        hb  = (m_phase == 1) && real_quarter;
        mb  = (m_phase == 2) && real_quarter;
        h12 = (h % 12 == 0) ? 12 : h % 12;
        if (!m_12h) begin
            d0 = hb ? 4'd11 : 4'(h / 10);
            d1 = hb ? 4'd11 : 4'(h % 10);
            d2 = mb ? 4'd11 : 4'(m / 10);
            d3 = mb ? 4'd11 : 4'(m % 10);
            d4 = 4'd0;
            d5 = 4'd0;
        end else begin
            d0 = (h < 12) ? 4'd12 : 4'd13;
            d1 = 4'd10;
            d2 = hb ? 4'd11 : 4'(h12 / 10);
            d3 = hb ? 4'd11 : 4'(h12 % 10);
            d4 = mb ? 4'd11 : 4'(m / 10);
            d5 = mb ? 4'd11 : 4'(m % 10);
        end
        return {d0, d1, d2, d3, d4, d5};
    endfunction

    function automatic logic [40:0] exp_state();
        return {SW'(m_sel), 5'(m_h[m_sel]), 6'(m_m[m_sel]), m_ring, SW'(m_rslot), m_snz, exp_dig()};
    endfunction

    // Drive one clock of stimulus and advance the model by the same clock.
    task automatic step(input logic s, input logic d, input logic c, input logic n,
                        input logic z, input logic t, input logic [1:0] md);
        logic active, ok;
        int   hit;
        currentMode = md; set = s; display = d; clear = c; next = n; snooze = z; minute_tick = t;
        active = m_ring | m_snz;
        ok     = (md == 2'd1);
        hit    = -1;
        if (t)
            for (int i = N - 1; i >= 0; i--)
                if (m_h[i] != 24 && m_h[i] == int'(cur_hours) && m_m[i] == int'(cur_minutes))
                    hit = i;
        if (c && active) begin
            m_ring = 1'b0; m_snz = 1'b0;
        end else if (z && m_ring) begin
            m_ring = 1'b0; m_snz = 1'b1; m_left = SNZ;
        end else if (m_snz && m_h[m_rslot] == 24) begin
            m_snz = 1'b0;
        end else if (t) begin
            if (m_ring) begin
                m_left--;
                if (m_left == 0) m_ring = 1'b0;
            end else if (m_snz) begin
                m_left--;
                if (m_left == 0) begin
                    m_snz = 1'b0; m_ring = 1'b1; m_left = RNG;
                end
            end else if (hit >= 0) begin
                m_ring = 1'b1; m_rslot = hit; m_left = RNG;
            end
        end
        if (ok && !(c && active)) begin
            if (c) begin
                if (m_phase == 0) m_h[m_sel] = 24;
                else m_phase = 0;
            end else if (s) begin
                if (m_phase == 0) begin
                    m_phase = 1;
                    m_eh = (m_h[m_sel] == 24) ? 0 : m_h[m_sel];
                    m_em = (m_h[m_sel] == 24) ? 0 : m_m[m_sel];
                end else if (m_phase == 1) begin
                    m_phase = 2;
                end else begin
                    m_h[m_sel] = m_eh; m_m[m_sel] = m_em; m_phase = 0;
                end
            end else if (d) begin
                if (m_phase == 0) m_12h = ~m_12h;
                else if (m_phase == 1) m_eh = (m_eh + 1) % 24;
                else m_em = (m_em + 1) % 60;
            end else if (n && m_phase == 0) begin
                m_sel = (m_sel + 1) % N;
            end
        end
        @(posedge clk);
        #1;
        set = 0; display = 0; clear = 0; next = 0; snooze = 0; minute_tick = 0;
    endtask

    task automatic press_set();  step(1, 0, 0, 0, 0, 0, 2'd1); endtask
    task automatic press_disp(); step(0, 1, 0, 0, 0, 0, 2'd1); endtask
    task automatic press_clr();  step(0, 0, 1, 0, 0, 0, 2'd1); endtask
    task automatic press_next(); step(0, 0, 0, 1, 0, 0, 2'd1); endtask

    task automatic tick_at(input int h, input int m);
        cur_hours = 5'(h); cur_minutes = 6'(m);
        step(0, 0, 0, 0, 0, 1, 2'd0);
    endtask

    task automatic program_slot(input int h, input int m);
        press_set();
        repeat ((h - m_eh + 24) % 24) press_disp();
        press_set();
        repeat ((m - m_em + 60) % 60) press_disp();
        press_set();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (sel_slot !== 2'd0) begin n_fail++; $display("FAIL reset_sel: got %0d expected 0", sel_slot); end
        n_cmp++; if (alarm_hours !== 5'd24) begin n_fail++; $display("FAIL reset_hours: got %0d expected 24", alarm_hours); end
        n_cmp++; if ({ring, snoozing, ring_slot} !== 4'b0) begin n_fail++; $display("FAIL reset_ring: got %b expected 0000", {ring, snoozing, ring_slot}); end
        n_cmp++; if (dut_dig !== 24'hBBBBBB) begin n_fail++; $display("FAIL reset_dig: got %h expected bbbbbb", dut_dig); end
    endtask

    task automatic test_program_24h();
        press_set();
        repeat (7) press_disp();
        press_set();
        repeat (30) press_disp();
        press_set();
        n_cmp++; if ({alarm_hours, alarm_minutes} !== {5'd7, 6'd30}) begin n_fail++; $display("FAIL prog_value: got %0d:%0d expected 7:30", alarm_hours, alarm_minutes); end
        n_cmp++; if (dut_dig !== 24'h073000) begin n_fail++; $display("FAIL prog_dig24: got %h expected 073000", dut_dig); end
    endtask

    task automatic test_12h();
        press_disp();
        n_cmp++; if (dut_dig !== 24'hCA0730) begin n_fail++; $display("FAIL h12_0730: got %h expected ca0730", dut_dig); end
        program_slot(13, 5);
        n_cmp++; if (dut_dig !== 24'hDA0105) begin n_fail++; $display("FAIL h12_1305: got %h expected da0105", dut_dig); end
        program_slot(0, 0);
        n_cmp++; if (dut_dig !== 24'hCA1200) begin n_fail++; $display("FAIL h12_0000: got %h expected ca1200", dut_dig); end
        press_disp();
        n_cmp++; if (dut_dig !== 24'h000000) begin n_fail++; $display("FAIL h24_back: got %h expected 000000", dut_dig); end
    endtask

    task automatic test_ring();
        program_slot(6, 0);
        press_next();
        press_next();
        program_slot(6, 0);
        tick_at(6, 0);
        n_cmp++; if ({ring, ring_slot} !== {1'b1, 2'd0}) begin n_fail++; $display("FAIL ring_start: got %b/%0d expected 1/0", ring, ring_slot); end
        tick_at(6, 1);
        n_cmp++; if (ring !== 1'b0) begin n_fail++; $display("FAIL ring_timeout: got %b expected 0", ring); end
    endtask

    task automatic test_snooze();
        tick_at(6, 0);
        step(0, 0, 0, 0, 1, 0, 2'd0);
        n_cmp++; if ({ring, snoozing} !== 2'b01) begin n_fail++; $display("FAIL snooze_enter: got %b expected 01", {ring, snoozing}); end
        for (int k = 1; k <= 4; k++) begin
            tick_at(6, k);
            n_cmp++; if ({ring, snoozing} !== 2'b01) begin n_fail++; $display("FAIL snooze_hold%0d: got %b expected 01", k, {ring, snoozing}); end
        end
        tick_at(6, 5);
        n_cmp++; if ({ring, snoozing, ring_slot} !== {2'b10, 2'd0}) begin n_fail++; $display("FAIL snooze_rering: got %b expected 1000", {ring, snoozing, ring_slot}); end
        step(0, 0, 1, 0, 1, 0, 2'd0);
        n_cmp++; if ({ring, snoozing} !== 2'b00) begin n_fail++; $display("FAIL clear_snooze: got %b expected 00", {ring, snoozing}); end
        n_cmp++; if (dut_state !== exp_state()) begin n_fail++; $display("FAIL after_clear: got %h expected %h", dut_state, exp_state()); end
    endtask

    task automatic test_blink_abort();
        press_next();
        press_next();
        n_cmp++; if (sel_slot !== 2'd0) begin n_fail++; $display("FAIL sel_wrap: got %0d expected 0", sel_slot); end
        press_set();
        real_quarter = 1'b1; #1;
        n_cmp++; if (dut_dig !== 24'hBB0000) begin n_fail++; $display("FAIL blink_hour: got %h expected bb0000", dut_dig); end
        press_set();
        n_cmp++; if (dut_dig !== 24'h06BB00) begin n_fail++; $display("FAIL blink_min_on: got %h expected 06bb00", dut_dig); end
        real_quarter = 1'b0; #1;
        n_cmp++; if (dut_dig !== 24'h060000) begin n_fail++; $display("FAIL blink_min_off: got %h expected 060000", dut_dig); end
        press_disp();
        press_clr();
        n_cmp++; if ({alarm_hours, alarm_minutes} !== {5'd6, 6'd0}) begin n_fail++; $display("FAIL abort_keep: got %0d:%0d expected 6:0", alarm_hours, alarm_minutes); end
        press_set();
        repeat (17) press_disp();
        n_cmp++; if (dut_dig !== 24'h230000) begin n_fail++; $display("FAIL hour_23: got %h expected 230000", dut_dig); end
        press_disp();
        n_cmp++; if (dut_dig !== 24'h000000) begin n_fail++; $display("FAIL hour_wrap: got %h expected 000000", dut_dig); end
        press_set();
        repeat (59) press_disp();
        n_cmp++; if (dut_dig !== 24'h005900) begin n_fail++; $display("FAIL min_59: got %h expected 005900", dut_dig); end
        press_disp();
        n_cmp++; if (dut_dig !== 24'h000000) begin n_fail++; $display("FAIL min_wrap: got %h expected 000000", dut_dig); end
        press_clr();
        n_cmp++; if (alarm_hours !== 5'd6) begin n_fail++; $display("FAIL abort2_keep: got %0d expected 6", alarm_hours); end
    endtask

    task automatic test_next_clear();
        repeat (N) press_next();
        n_cmp++; if (sel_slot !== 2'd0) begin n_fail++; $display("FAIL next_cycle: got %0d expected 0", sel_slot); end
        press_clr();
        n_cmp++; if (alarm_hours !== 5'd24) begin n_fail++; $display("FAIL clear_slot: got %0d expected 24", alarm_hours); end
        n_cmp++; if (dut_dig !== 24'hBBBBBB) begin n_fail++; $display("FAIL clear_dig: got %h expected bbbbbb", dut_dig); end
    endtask

    task automatic test_reset_mid();
        tick_at(6, 0);
        n_cmp++; if ({ring, ring_slot} !== {1'b1, 2'd2}) begin n_fail++; $display("FAIL ring_slot2: got %b/%0d expected 1/2", ring, ring_slot); end
        #2;
        reset = 1'b1;
        #1;
        n_cmp++; if (ring !== 1'b0) begin n_fail++; $display("FAIL async_silence: got %b expected 0", ring); end
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        press_next();
        press_set();
        press_disp();
        do_reset();
        n_cmp++; if (dut_dig !== 24'hBBBBBB) begin n_fail++; $display("FAIL reset_edit_dig: got %h expected bbbbbb", dut_dig); end
        for (int i = 0; i < N; i++) begin
            n_cmp++; if (alarm_hours !== 5'd24) begin n_fail++; $display("FAIL reset_slot%0d: got %0d expected 24", i, alarm_hours); end
            press_next();
        end
    endtask

    task automatic test_random();
        int slot;
        logic s, d, c, n, z, t;
        logic [1:0] md;
        for (int k = 0; k < 1500; k++) begin
            s = ($urandom_range(0, 7) == 0);
            d = ($urandom_range(0, 2) == 0);
            c = ($urandom_range(0, 19) == 0);
            n = ($urandom_range(0, 5) == 0);
            z = ($urandom_range(0, 9) == 0);
            t = ($urandom_range(0, 4) == 0);
            md = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'd1;
            real_quarter = 1'($urandom_range(0, 1));
            slot = $urandom_range(0, N - 1);
            if ($urandom_range(0, 1) == 1 && m_h[slot] != 24) begin
                cur_hours = 5'(m_h[slot]); cur_minutes = 6'(m_m[slot]);
            end else begin
                cur_hours = 5'($urandom_range(0, 23)); cur_minutes = 6'($urandom_range(0, 59));
            end
            step(s, d, c, n, z, t, md);
            n_cmp++;
            if (dut_state !== exp_state()) begin
                n_fail++;
                $display("FAIL random_%0d: got %h expected %h", k, dut_state, exp_state());
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_program_24h();
        test_12h();
        test_ring();
        test_snooze();
        test_blink_abort();
        test_next_clear();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
